// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package mem_lsu_pkg;

    // Width of one byte lane in the 32-bit data word.
    localparam int LANE_W = 8;

    // Request size encodings as they arrive on req_size.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // True when the access cannot be served as one aligned lane.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            SIZE_W:  mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// master = core memory stage, slave = mem_lsu.
interface mem_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_misaligned;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Lane logic: extracts and extends sub-word loads, and merges sub-word
// store data into the word read from RAM. Purely combinational.
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  zero_ext,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_word
);
    localparam int HALF_W = 2 * LANE_W;

    logic [4:0]        bit_off;
    logic [LANE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    assign bit_off   = {offset, 3'b000};
    assign byte_lane = word[bit_off +: LANE_W];
    assign half_lane = offset[1] ? word[DATA_WIDTH-1:HALF_W] : word[HALF_W-1:0];

    // Select the addressed lane and sign/zero-extend it; build the merged store word.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        load_data  = word;
        store_word = wdata;
        case (size)
            SIZE_B: begin
                load_data  = {{(DATA_WIDTH-LANE_W){~zero_ext & byte_lane[LANE_W-1]}}, byte_lane};
                store_word = word;
                store_word[bit_off +: LANE_W] = wdata[LANE_W-1:0];
            end
            SIZE_H: begin
                load_data  = {{(DATA_WIDTH-HALF_W){~zero_ext & half_lane[HALF_W-1]}}, half_lane};
                store_word = word;
                if (offset[1]) store_word[DATA_WIDTH-1:HALF_W] = wdata[HALF_W-1:0];
                else           store_word[HALF_W-1:0]          = wdata[HALF_W-1:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a word-addressed RAM with one write enable.
// Sub-word stores use a read-modify-write through the WRITE state.
// Build option MEM_LSU_MISALIGN_TRAP_EN: report misaligned accesses instead
// of force-aligning them.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_lsu_if.slave              core,
    output logic                  mem_wEn,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);
    state_t                state, state_next;
    logic                  accept;
    logic                  misaligned;
    logic                  sub_word;
    logic                  wen_raw;

    logic [1:0]            size_in;
    logic [ADDR_WIDTH+1:0] addr_in;

    logic                  write_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged_q;

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_mis_q;

    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    assign core.req_ready      = (state == ST_IDLE) && !reset;
    assign accept              = core.req_valid && core.req_ready;
    assign core.resp_valid     = resp_valid_q;
    assign core.resp_rdata     = resp_rdata_q;
    assign mem_address         = addr_q[ADDR_WIDTH+1:2];
    assign sub_word            = (size_q == SIZE_B) || (size_q == SIZE_H);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign size_in             = core.req_size;
    assign addr_in             = core.req_addr;
    assign misaligned          = is_misaligned(size_q, addr_q[1:0]);
    assign core.resp_misaligned = resp_mis_q;
`else
    // Force-align at accept time so every performed access is legal.
    always_comb begin
        size_in = (core.req_size == SIZE_X) ? SIZE_W : core.req_size;
        addr_in = core.req_addr;
        if (size_in == SIZE_H) addr_in[0]   = 1'b0;
        if (size_in == SIZE_W) addr_in[1:0] = 2'b00;
    end
    assign misaligned          = 1'b0;
    assign core.resp_misaligned = 1'b0;
`endif

    mem_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word       (mem_read_data),
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .zero_ext   (uns_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and RAM-port control.
    always_comb begin
        state_next     = state;
        wen_raw        = 1'b0;
        mem_write_data = wdata_q;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (misaligned) begin
                    state_next = ST_IDLE;
                end else if (write_q && !sub_word) begin
                    wen_raw    = 1'b1;
                    state_next = ST_IDLE;
                end else if (write_q) begin
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wen_raw        = 1'b1;
                mem_write_data = merged_q;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A reset edge must never write RAM, even in the middle of an RMW.
    assign mem_wEn = wen_raw && !reset;

    // Request capture, RMW merge register and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q      <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            if (accept) begin
                write_q <= core.req_write;
                size_q  <= size_in;
                uns_q   <= core.req_unsigned;
                addr_q  <= addr_in;
                wdata_q <= core.req_wdata;
            end
            case (state)
                ST_ACCESS: begin
                    if (misaligned) begin
                        resp_valid_q <= 1'b1;
                        resp_mis_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else if (!write_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end else if (!sub_word) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        merged_q <= store_word;
                    end
                end
                ST_WRITE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural RAM model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clock;
    logic        reset;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] ram [0:65535];
    int          wr_count;
    int          cyc;
    int          tests_run;
    int          tests_failed;

    mem_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .core           (bus),
        .mem_wEn        (mem_wEn),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational-read, posedge-write RAM.
    assign mem_read_data = ram[mem_address];
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (mem_wEn) begin
            ram[mem_address] = mem_write_data;
            wr_count = wr_count + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Issue one request and wait for its response; latency counts edges from accept.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [17:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata,
                          output logic mis, output logic [7:0] wtrace);
        int guard;
        lat = -1; rdata = '0; mis = 1'b0; wtrace = '0; guard = 0;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        while (!bus.req_ready && guard < 10) begin
            @(posedge clock); #1; guard++;
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wtrace[i] = mem_wEn;
            @(posedge clock); #1;
            if (bus.resp_valid) begin
                lat = i + 1; rdata = bus.resp_rdata; mis = bus.resp_misaligned;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        tests_run++;
        if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low: got %b expected 0", bus.req_ready); end
        tests_run++;
        if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        tests_run++;
        if (mem_wEn !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b expected 0", mem_wEn); end
        tests_run++;
        if (mem_address !== 16'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0000", mem_address); end
        tests_run++;
        if (bus.resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", bus.resp_rdata); end
        reset = 1'b0; #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [5] = '{SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_B};
        logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [17:0] ad  [5] = '{18'h41, 18'h41, 18'h42, 18'h40, 18'h43};
        logic [31:0] ex  [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB, 32'h00000088};
        int lat; logic [31:0] rd; logic mis; logic [7:0] wt;
        ram[16'h10] = 32'h8899AABB;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, mis, wt);
            tests_run++;
            if (rd !== ex[i]) begin tests_failed++; $display("FAIL load_data[%0d]: got %h expected %h", i, rd, ex[i]); end
            tests_run++;
            if (lat !== 1) begin tests_failed++; $display("FAIL load_latency[%0d]: got %0d expected 1", i, lat); end
            tests_run++;
            if (wt[0] !== 1'b0) begin tests_failed++; $display("FAIL load_wen[%0d]: got %b expected 0", i, wt[0]); end
        end
    endtask

    task automatic test_subword_store();
        int lat; logic [31:0] rd; logic mis; logic [7:0] wt; int w0;
        ram[16'h10] = 32'h11223344;
        w0 = wr_count;
        do_req(1'b1, SIZE_H, 1'b0, 18'h42, 32'h0000BEEF, lat, rd, mis, wt);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL sh_latency: got %0d expected 2", lat); end
        tests_run++;
        if (wt[1:0] !== 2'b10) begin tests_failed++; $display("FAIL sh_wen_seq: got %b expected 10", wt[1:0]); end
        tests_run++;
        if (ram[16'h10] !== 32'hBEEF3344) begin tests_failed++; $display("FAIL sh_ram: got %h expected BEEF3344", ram[16'h10]); end
        tests_run++;
        if (wr_count - w0 !== 1) begin tests_failed++; $display("FAIL sh_write_count: got %0d expected 1", wr_count - w0); end
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL sh_rdata: got %h expected 0", rd); end
        do_req(1'b0, SIZE_W, 1'b0, 18'h40, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (rd !== 32'hBEEF3344) begin tests_failed++; $display("FAIL sh_readback: got %h expected BEEF3344", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic mis; logic [7:0] wt; int w0; int c0;
        w0 = wr_count;
        do_req(1'b1, SIZE_W, 1'b0, 18'h44, 32'hDEADBEEF, lat, rd, mis, wt);
        tests_run++;
        if (lat !== 1 || wt[0] !== 1'b1) begin tests_failed++; $display("FAIL sw_timing: got lat %0d wen %b expected lat 1 wen 1", lat, wt[0]); end
        tests_run++;
        if (wr_count - w0 !== 1) begin tests_failed++; $display("FAIL sw_write_count: got %0d expected 1", wr_count - w0); end
        tests_run++;
        if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b expected 1", bus.req_ready); end
        c0 = cyc;
        do_req(1'b0, SIZE_W, 1'b0, 18'h44, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL b2b_lw: got %h expected DEADBEEF", rd); end
        tests_run++;
        if (cyc - c0 !== 2) begin tests_failed++; $display("FAIL b2b_cycles: got %0d expected 2", cyc - c0); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic mis; logic [7:0] wt; int w0;
        ram[16'h10] = 32'h11223344;
        w0 = wr_count;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        do_req(1'b0, SIZE_W, 1'b0, 18'h42, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (mis !== 1'b1 || rd !== 32'h0 || lat !== 1) begin tests_failed++; $display("FAIL mis_lw: got mis %b data %h lat %0d expected 1 0 1", mis, rd, lat); end
        do_req(1'b1, SIZE_H, 1'b0, 18'h43, 32'h0000FFFF, lat, rd, mis, wt);
        tests_run++;
        if (mis !== 1'b1) begin tests_failed++; $display("FAIL mis_sh_flag: got %b expected 1", mis); end
        tests_run++;
        if (ram[16'h10] !== 32'h11223344) begin tests_failed++; $display("FAIL mis_sh_ram: got %h expected 11223344", ram[16'h10]); end
        tests_run++;
        if (wr_count !== w0) begin tests_failed++; $display("FAIL mis_no_write: got %0d writes expected 0", wr_count - w0); end
        do_req(1'b0, SIZE_X, 1'b0, 18'h40, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (mis !== 1'b1) begin tests_failed++; $display("FAIL mis_size3: got %b expected 1", mis); end
`else
        do_req(1'b0, SIZE_W, 1'b0, 18'h42, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (rd !== 32'h11223344 || mis !== 1'b0) begin tests_failed++; $display("FAIL align_lw: got %h mis %b expected 11223344 0", rd, mis); end
        do_req(1'b0, SIZE_X, 1'b0, 18'h41, 32'h0, lat, rd, mis, wt);
        tests_run++;
        if (rd !== 32'h11223344) begin tests_failed++; $display("FAIL align_size3: got %h expected 11223344", rd); end
        do_req(1'b1, SIZE_H, 1'b0, 18'h43, 32'h00005566, lat, rd, mis, wt);
        tests_run++;
        if (ram[16'h10] !== 32'h55663344 || lat !== 2) begin tests_failed++; $display("FAIL align_sh: got %h lat %0d expected 55663344 2", ram[16'h10], lat); end
        tests_run++;
        if (wr_count - w0 !== 1) begin tests_failed++; $display("FAIL align_sh_writes: got %0d expected 1", wr_count - w0); end
`endif
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        ram[16'h12] = 32'hCAFEF00D;
        w0 = wr_count;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SIZE_B;
        bus.req_unsigned = 1'b0; bus.req_addr = 18'h49; bus.req_wdata = 32'h00000077;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (mem_wEn !== 1'b1) begin tests_failed++; $display("FAIL rmw_in_write: got %b expected 1", mem_wEn); end
        reset = 1'b1; #1;
        tests_run++;
        if (mem_wEn !== 1'b0) begin tests_failed++; $display("FAIL rmw_reset_wen: got %b expected 0", mem_wEn); end
        @(posedge clock); #1;
        tests_run++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rmw_reset_outputs: got valid %b ready %b expected 0 0", bus.resp_valid, bus.req_ready); end
        reset = 1'b0; #1;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rmw_ready_after: got %b expected 1", bus.req_ready); end
        tests_run++;
        if (ram[16'h12] !== 32'hCAFEF00D || wr_count !== w0) begin tests_failed++; $display("FAIL rmw_ram_intact: got %h writes %0d expected CAFEF00D 0", ram[16'h12], wr_count - w0); end
        tests_run++;
        if (mem_address !== 16'h0 || bus.resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rmw_regs_cleared: got addr %h rdata %h expected 0 0", mem_address, bus.resp_rdata); end
    endtask

    task automatic test_stream_loads();
        logic [17:0] ad [3] = '{18'h80, 18'h84, 18'h88};
        logic [31:0] ex [3] = '{32'h0A0A0A01, 32'h0B0B0B02, 32'h0C0C0C03};
        int issued; int got; logic prev_acc;
        ram[16'h20] = ex[0]; ram[16'h21] = ex[1]; ram[16'h22] = ex[2];
        issued = 0; got = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SIZE_W;
        bus.req_unsigned = 1'b0; bus.req_addr = ad[0]; bus.req_wdata = 32'h0;
        prev_acc = bus.req_valid && bus.req_ready;
        for (int c = 0; c < 14; c++) begin
            @(posedge clock); #1;
            if (prev_acc) begin
                issued++;
                if (issued < 3) bus.req_addr = ad[issued];
                else bus.req_valid = 1'b0;
            end
            if (bus.resp_valid) begin
                if (got < 3) begin
                    tests_run++;
                    if (bus.resp_rdata !== ex[got]) begin tests_failed++; $display("FAIL stream_data[%0d]: got %h expected %h", got, bus.resp_rdata, ex[got]); end
                end
                got++;
            end
            prev_acc = bus.req_valid && bus.req_ready;
        end
        tests_run++;
        if (got !== 3) begin tests_failed++; $display("FAIL stream_pulses: got %0d expected 3", got); end
        tests_run++;
        if (issued !== 3) begin tests_failed++; $display("FAIL stream_accepts: got %0d expected 3", issued); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; wr_count = 0; cyc = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SIZE_B;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        test_reset();
        test_load_ext();
        test_subword_store();
        test_back_to_back();
        test_misalign();
        test_reset_mid_rmw();
        test_stream_loads();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
